mul_wb_tracker: RTL and testbench
=================================

# mul_wb_tracker

Writeback tracker and result buffer placed directly downstream of the pipelined integer multiplier. It accepts M-extension multiply issues, carries each instruction's destination register alongside the multiplier's LATENCY-stage pipeline, captures the 32-bit product when that instruction reaches the multiplier output, and queues it for the register-file writeback arbiter over a valid/ready handshake. It also drives the multiplier's pipeline advance enable, so the multiplier freezes whenever the result buffer cannot absorb another product.

## Interface
Parameters:
- LATENCY, 2: cycles from issue acceptance until the product is valid on mul_result_i; must be ≥1.
- FIFO_DEPTH, 2: result buffer entries; must be a power of two and ≥2.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- issue_valid_i  in  1  an instruction is offered to the multiplier this cycle.
- issue_opcode_i  in  32  instruction word of the offered instruction.
- issue_ready_o  out  1  issue accepted this cycle; equals mul_advance_o.
- flush_i  in  1  kill all in-flight multiplies that are not yet buffered.
- mul_result_i  in  32  multiplier writeback value (combinational output of its final stage).
- mul_advance_o  out  1  enables the multiplier pipeline registers this cycle.
- wb_valid_o  out  1  buffer head holds a result.
- wb_ready_i  in  1  arbiter consumes the head this cycle.
- wb_rd_o  out  5  destination register of the head entry.
- wb_value_o  out  32  result value of the head entry.
- busy_o  out  1  any tracker slot or buffer entry is valid.

## Operation
- Decode: an instruction is a tracked multiply when opcode[6:0]=0110011, funct7=0000001 and funct3[2]=0 (MUL, MULH, MULHSU, MULHU). Any other offered opcode is accepted as a bubble: it enters the tracker with the valid bit clear.
- Tracker: a LATENCY-deep shift register of {valid, rd[4:0]}. It shifts one slot per cycle when mul_advance_o=1 and holds otherwise. The tail slot corresponds to the value currently on mul_result_i.
- FIFO: FIFO_DEPTH entries of {rd, value}. The count ranges 0..FIFO_DEPTH, and the pointers wrap modulo FIFO_DEPTH.
- Push: occurs when the tail slot is valid, tail rd≠0 and mul_advance_o=1. Tail entries with rd=0 are discarded, but the tracker still advances.
- Pop: occurs when wb_valid_o=1 and wb_ready_i=1.
- Stall rule: mul_advance_o = !(tail valid && tail rd≠0 && FIFO full && !pop).
  - A push and a pop in the same cycle on a full FIFO are legal; the count is unchanged.
  - This creates a combinational path from wb_ready_i to mul_advance_o and issue_ready_o.
- Simultaneous push and pop on an empty FIFO: not possible, because head data is registered. The pushed entry appears the next cycle.
- Flush: clears every tracker valid bit at the clock edge, including a slot being shifted in that cycle.
  - A push occurring in the same cycle still completes, because the tail was already produced.
  - Buffered FIFO entries are retained.
- wb_rd_o and wb_value_o are stable while wb_valid_o=1 and wb_ready_i=0.

## Timing
- Reset values:
  - wb_valid_o=0, wb_rd_o=0, wb_value_o=0, busy_o=0.
  - Tracker and FIFO are empty.
  - issue_ready_o=mul_advance_o=1, since both are combinational from the empty state.
- Latency: a multiply accepted in cycle N is sampled from mul_result_i in cycle N+LATENCY. It is pushed at the edge ending that cycle, and wb_valid_o rises in cycle N+LATENCY+1 at the earliest.
- Throughput: one issue per cycle while wb_ready_i=1.
- With wb_ready_i held at 0: exactly FIFO_DEPTH results are buffered, after which mul_advance_o falls once a valid non-zero-rd tail is present.
- Reset mid-operation: all in-flight and buffered results are lost immediately.
- busy_o is registered: it reflects the post-edge state of the tracker and FIFO.

## Configuration
- MUL_WB_TRACKER_FWD_EN: adds the following forwarding ports for hazard logic.
  - fwd_rd_i (in, 5).
  - fwd_hit_o (out, 1): high when any valid tracker slot or FIFO entry has rd==fwd_rd_i≠0.
  - fwd_avail_o (out, 1): high when the youngest match is in the FIFO or in the tail slot.
  - fwd_value_o (out, 32): the youngest match's value; mul_result_i for a tail match, the FIFO value otherwise.
- Without the macro: these ports are absent and no comparison logic is built.

## Test plan
- Reset, then issue MUL x5 (rd=5) with the multiplier returning 0x0000_0015 → wb_valid_o=1 in cycle 3 after issue (LATENCY=2), wb_rd_o=5, wb_value_o=0x15, busy_o returns to 0 after the pop.
- Back-to-back issues to rd=1..4 with wb_ready_i=1 → four consecutive writebacks in issue order with no stall.
- Hold wb_ready_i=0 and issue rd=1..4 continuously → 2 entries buffered, mul_advance_o=0 while rd=3 sits in the tail; raise wb_ready_i → rd=3 pushed in the same cycle as a pop, with no loss.
- Issue rd=0 MUL and a DIV opcode among valid multiplies → neither produces a writeback; the other results are unaffected.
- Assert flush_i one cycle after issuing rd=7 → rd=7 never appears; an entry already buffered is still written back.
- With MUL_WB_TRACKER_FWD_EN defined: fwd_rd_i=9 during rd=9 in-flight → fwd_hit_o=1, fwd_avail_o=0 until the tail cycle, then fwd_avail_o=1 with fwd_value_o=mul_result_i.

Source files
------------

// File: rtl/mul_wb_tracker.sv
// mul_wb_tracker: tracks multiplier destination registers through the multiplier
// pipeline and queues products for register-file writeback. Rev 1.0. Optional: MUL_WB_TRACKER_FWD_EN.
`default_nettype none

module mul_wb_tracker #(
  parameter int LATENCY    = 2,
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic [31:0] issue_opcode_i,
  output logic        issue_ready_o,
  input  logic        flush_i,
  input  logic [31:0] mul_result_i,
  output logic        mul_advance_o,
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_value_o,
`ifdef MUL_WB_TRACKER_FWD_EN
  input  logic [4:0]  fwd_rd_i,
  output logic        fwd_hit_o,
  output logic        fwd_avail_o,
  output logic [31:0] fwd_value_o,
`endif
  output logic        busy_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [LATENCY-1:0] trk_valid, trk_valid_nxt;
  logic [4:0]         trk_rd     [LATENCY];
  logic [4:0]         trk_rd_nxt [LATENCY];
  logic [4:0]         fifo_rd    [FIFO_DEPTH];
  logic [31:0]        fifo_val   [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_nxt;
  logic               busy_q;

  logic       is_mul, tail_valid, push_req, full, pop, push, advance;
  logic [4:0] issue_rd, tail_rd;
  logic       unused_opcode_bits;

  assign unused_opcode_bits = &{1'b0, issue_opcode_i[24:15], issue_opcode_i[13:12]};

  assign is_mul     = (issue_opcode_i[6:0] == 7'b0110011) &&
                      (issue_opcode_i[31:25] == 7'b0000001) && !issue_opcode_i[14];
  assign issue_rd   = issue_opcode_i[11:7];
  assign tail_valid = trk_valid[LATENCY-1];
  assign tail_rd    = trk_rd[LATENCY-1];
  assign push_req   = tail_valid && (tail_rd != 5'd0);
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign wb_valid_o = (count != '0);
  assign pop        = wb_valid_o && wb_ready_i;
  // A pop frees a slot in the same cycle, so a full buffer only stalls without one.
  assign advance    = !(push_req && full && !pop);
  assign push       = push_req && advance;

  assign mul_advance_o = advance;
  assign issue_ready_o = advance;
  assign wb_rd_o       = fifo_rd[rd_ptr];
  assign wb_value_o    = fifo_val[rd_ptr];
  assign busy_o        = busy_q;

  always_comb begin
    trk_valid_nxt = trk_valid;
    trk_rd_nxt    = trk_rd;
    count_nxt     = count;
    if (advance) begin
      trk_valid_nxt[0] = issue_valid_i && is_mul;
      trk_rd_nxt[0]    = issue_rd;
      for (int i = 1; i < LATENCY; i++) begin
        trk_valid_nxt[i] = trk_valid[i-1];
        trk_rd_nxt[i]    = trk_rd[i-1];
      end
    end
    if (flush_i) begin
      trk_valid_nxt = '0;
    end
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      trk_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        trk_rd[i] <= '0;
      end
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        fifo_rd[k]  <= '0;
        fifo_val[k] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy_q <= 1'b0;
    end else begin
      trk_valid <= trk_valid_nxt;
      trk_rd    <= trk_rd_nxt;
      count     <= count_nxt;
      busy_q    <= (|trk_valid_nxt) || (count_nxt != '0);
      if (push) begin
        fifo_rd[wr_ptr]  <= tail_rd;
        fifo_val[wr_ptr] <= mul_result_i;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

`ifdef MUL_WB_TRACKER_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Scan oldest to youngest so the last match seen is the youngest producer.
  always_comb begin
    fwd_hit_o   = 1'b0;
    fwd_avail_o = 1'b0;
    fwd_value_o = '0;
    fwd_idx     = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      fwd_idx = rd_ptr + PTR_W'(k);
      if ((CNT_W'(k) < count) && (fifo_rd[fwd_idx] == fwd_rd_i)) begin
        fwd_hit_o   = 1'b1;
        fwd_avail_o = 1'b1;
        fwd_value_o = fifo_val[fwd_idx];
      end
    end
    for (int i = LATENCY - 1; i >= 0; i--) begin
      if (trk_valid[i] && (trk_rd[i] == fwd_rd_i)) begin
        fwd_hit_o   = 1'b1;
        fwd_avail_o = (i == LATENCY - 1);
        fwd_value_o = (i == LATENCY - 1) ? mul_result_i : 32'd0;
      end
    end
    if (fwd_rd_i == 5'd0) begin
      fwd_hit_o   = 1'b0;
      fwd_avail_o = 1'b0;
      fwd_value_o = '0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul_wb_tracker.sv
// Directed bench for mul_wb_tracker (LATENCY=2, FIFO_DEPTH=2) with a small multiplier pipeline model.
`default_nettype none

module tb_mul_wb_tracker;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        issue_valid_i;
  logic [31:0] issue_opcode_i;
  logic        issue_ready_o;
  logic        flush_i;
  logic [31:0] mul_result_i;
  logic        mul_advance_o;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_value_o;
  logic        busy_o;
`ifdef MUL_WB_TRACKER_FWD_EN
  logic [4:0]  fwd_rd_i;
  logic        fwd_hit_o;
  logic        fwd_avail_o;
  logic [31:0] fwd_value_o;
`endif

  logic [31:0] op_val;
  logic [31:0] p0, p1;
  int checks = 0;
  int errors = 0;

  mul_wb_tracker #(.LATENCY(2), .FIFO_DEPTH(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .issue_valid_i  (issue_valid_i),
    .issue_opcode_i (issue_opcode_i),
    .issue_ready_o  (issue_ready_o),
    .flush_i        (flush_i),
    .mul_result_i   (mul_result_i),
    .mul_advance_o  (mul_advance_o),
    .wb_valid_o     (wb_valid_o),
    .wb_ready_i     (wb_ready_i),
    .wb_rd_o        (wb_rd_o),
    .wb_value_o     (wb_value_o),
`ifdef MUL_WB_TRACKER_FWD_EN
    .fwd_rd_i       (fwd_rd_i),
    .fwd_hit_o      (fwd_hit_o),
    .fwd_avail_o    (fwd_avail_o),
    .fwd_value_o    (fwd_value_o),
`endif
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Two-stage multiplier stand-in, frozen by the tracker's advance enable.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      p0 <= '0;
      p1 <= '0;
    end else if (mul_advance_o) begin
      p1 <= p0;
      p0 <= op_val;
    end
  end
  assign mul_result_i = p1;

  function automatic logic [31:0] mul_op(input logic [4:0] rd, input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  task automatic step(input logic v, input logic [31:0] op, input logic [31:0] val,
                      input logic rdy, input logic fl);
    @(negedge clk_i);
    issue_valid_i  = v;
    issue_opcode_i = op;
    op_val         = val;
    wb_ready_i     = rdy;
    flush_i        = fl;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    issue_valid_i = 1'b0;
    issue_opcode_i = '0;
    op_val = '0;
    flush_i = 1'b0;
    wb_ready_i = 1'b0;
`ifdef MUL_WB_TRACKER_FWD_EN
    fwd_rd_i = 5'd0;
`endif
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_rd", wb_rd_o, 0);
    check("rst_wb_value", wb_value_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_advance", mul_advance_o, 1);
    check("rst_issue_ready", issue_ready_o, 1);
    rst_i = 1'b0;

    // Single MUL x5, held one cycle at the head before being consumed
    step(1, mul_op(5'd5, 3'b000), 32'h15, 0, 0);
    check("t1_issue_ready", issue_ready_o, 1);
    check("t1_busy_issue", busy_o, 0);
    step(0, 0, 0, 0, 0);
    check("t1_busy_inflight", busy_o, 1);
    check("t1_valid_c1", wb_valid_o, 0);
    step(0, 0, 0, 0, 0);
    check("t1_valid_c2", wb_valid_o, 0);
    step(0, 0, 0, 0, 0);
    check("t1_valid_c3", wb_valid_o, 1);
    check("t1_rd_c3", wb_rd_o, 5);
    check("t1_value_c3", wb_value_o, 32'h15);
    step(0, 0, 0, 1, 0);
    check("t1_valid_hold", wb_valid_o, 1);
    check("t1_rd_hold", wb_rd_o, 5);
    check("t1_value_hold", wb_value_o, 32'h15);
    step(0, 0, 0, 1, 0);
    check("t1_valid_after_pop", wb_valid_o, 0);
    check("t1_busy_after_pop", busy_o, 0);

    // Back-to-back rd=1..4 with the arbiter always ready
    for (int t = 0; t < 8; t++) begin
      step(t < 4, mul_op(5'(t + 1), 3'b000), 32'h100 + 32'(t + 1), 1, 0);
      check("t2_advance", mul_advance_o, 1);
      if (t >= 3 && t <= 6) begin
        check("t2_valid", wb_valid_o, 1);
        check("t2_rd", wb_rd_o, 32'(t - 2));
        check("t2_value", wb_value_o, 32'h100 + 32'(t - 2));
      end else begin
        check("t2_idle", wb_valid_o, 0);
      end
    end
    step(0, 0, 0, 1, 0);
    check("t2_busy_done", busy_o, 0);

    // Arbiter blocked: two results buffered, rd=3 stalls in the tail
    for (int t = 0; t < 4; t++) begin
      step(1, mul_op(5'(t + 1), 3'b000), 32'h200 + 32'(t + 1), 0, 0);
      check("t3_issue_ready", issue_ready_o, 1);
    end
    for (int t = 4; t < 6; t++) begin
      step(0, 0, 0, 0, 0);
      check("t3_stall_adv", mul_advance_o, 0);
      check("t3_stall_ready", issue_ready_o, 0);
      check("t3_stall_valid", wb_valid_o, 1);
      check("t3_stall_rd", wb_rd_o, 1);
    end
    for (int t = 6; t < 10; t++) begin
      step(0, 0, 0, 1, 0);
      check("t3_drain_adv", mul_advance_o, 1);
      check("t3_drain_valid", wb_valid_o, 1);
      check("t3_drain_rd", wb_rd_o, 32'(t - 5));
      check("t3_drain_value", wb_value_o, 32'h200 + 32'(t - 5));
    end
    step(0, 0, 0, 1, 0);
    check("t3_empty", wb_valid_o, 0);
    check("t3_busy", busy_o, 0);

    // rd=0 MUL and a DIV are swallowed; MUL and MULHU around them write back
    step(1, mul_op(5'd10, 3'b000), 32'hA0A0, 1, 0);
    check("t4_c0", wb_valid_o, 0);
    step(1, mul_op(5'd0, 3'b000), 32'hB0B0, 1, 0);
    check("t4_c1", wb_valid_o, 0);
    step(1, mul_op(5'd11, 3'b100), 32'hC0C0, 1, 0);
    check("t4_c2", wb_valid_o, 0);
    step(1, mul_op(5'd12, 3'b011), 32'hD0D0, 1, 0);
    check("t4_c3_valid", wb_valid_o, 1);
    check("t4_c3_rd", wb_rd_o, 10);
    check("t4_c3_value", wb_value_o, 32'hA0A0);
    step(0, 0, 0, 1, 0);
    check("t4_rd0_dropped", wb_valid_o, 0);
    step(0, 0, 0, 1, 0);
    check("t4_div_dropped", wb_valid_o, 0);
    step(0, 0, 0, 1, 0);
    check("t4_c6_valid", wb_valid_o, 1);
    check("t4_c6_rd", wb_rd_o, 12);
    check("t4_c6_value", wb_value_o, 32'hD0D0);
    step(0, 0, 0, 1, 0);
    check("t4_busy", busy_o, 0);

    // Flush kills rd=7 in flight while rd=6 is pushed and kept
    step(1, mul_op(5'd6, 3'b000), 32'h66, 0, 0);
    step(1, mul_op(5'd7, 3'b001), 32'h77, 0, 0);
    step(0, 0, 0, 0, 1);
    check("t5_flush_cycle", wb_valid_o, 0);
    step(0, 0, 0, 0, 0);
    check("t5_kept_valid", wb_valid_o, 1);
    check("t5_kept_rd", wb_rd_o, 6);
    check("t5_kept_value", wb_value_o, 32'h66);
    check("t5_busy_fifo", busy_o, 1);
    step(0, 0, 0, 1, 0);
    check("t5_pop_rd", wb_rd_o, 6);
    step(0, 0, 0, 0, 0);
    check("t5_no_rd7", wb_valid_o, 0);
    check("t5_busy_clear", busy_o, 0);
    step(0, 0, 0, 0, 0);
    check("t5_no_rd7_late", wb_valid_o, 0);

    // Asynchronous reset discards a buffered result at once
    step(1, mul_op(5'd8, 3'b000), 32'h88, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("t6_buffered", wb_valid_o, 1);
    rst_i = 1'b1;
    #1;
    check("t6_rst_valid", wb_valid_o, 0);
    check("t6_rst_rd", wb_rd_o, 0);
    check("t6_rst_busy", busy_o, 0);
    check("t6_rst_adv", mul_advance_o, 1);
    step(0, 0, 0, 0, 0);
    rst_i = 1'b0;

`ifdef MUL_WB_TRACKER_FWD_EN
    fwd_rd_i = 5'd9;
    step(1, mul_op(5'd9, 3'b000), 32'h99, 0, 0);
    check("fwd_c0_hit", fwd_hit_o, 0);
    step(0, 0, 0, 0, 0);
    check("fwd_c1_hit", fwd_hit_o, 1);
    check("fwd_c1_avail", fwd_avail_o, 0);
    step(0, 0, 0, 0, 0);
    check("fwd_tail_hit", fwd_hit_o, 1);
    check("fwd_tail_avail", fwd_avail_o, 1);
    check("fwd_tail_value", fwd_value_o, 32'h99);
    step(0, 0, 0, 0, 0);
    check("fwd_fifo_avail", fwd_avail_o, 1);
    check("fwd_fifo_value", fwd_value_o, 32'h99);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("fwd_gone", fwd_hit_o, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
